keypad_code_entry: RTL

// - Upstream stage of the serial-check lock FSM: gathers decimal key presses into one binary code word for it.
// - Assembles NUM_DIGITS digits, most significant first, into their binary value on code (5,9,3,8 -> 16'h1732 = 5938).
// - Presents code with a valid/ready handshake; handles CLEAR, ENTER and inter-key timeout; flags malformed entries.

---
 rtl/keypad_code_entry_pkg.sv | 8 +
 rtl/keypad_code_entry_timer.sv | 19 +
 rtl/keypad_code_entry.sv | 110 +++++++++++
 3 files changed

// File: rtl/keypad_code_entry_pkg.sv
// keypad_code_entry_pkg: key encodings, FSM states and default sizing shared by the keypad entry block.
package keypad_code_entry_pkg;
  localparam int NUM_DIGITS_DEF = 4;
  localparam int CODE_W_DEF = 16;
  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  typedef enum logic [1:0] {IDLE, ENTRY, HOLD} state_e;
endpackage

// File: rtl/keypad_code_entry_timer.sv
// entry_timer: reloadable down-counter flagging inter-key timeout; expired on the last idle cycle of the window.
module entry_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? W'(TIMEOUT_CYCLES) : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  assign expired_o = cnt_q <= W'(1);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/keypad_code_entry.sv
// keypad_code_entry: assembles decimal key presses into a binary code word and hands it off via valid/ready.
module keypad_code_entry
  import keypad_code_entry_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int CODE_W = CODE_W_DEF,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid_i,
  input  logic [3:0]        key_code_i,
  output logic [CODE_W-1:0] code_o,
  output logic              code_valid_o,
  input  logic              code_ready_i,
  output logic [2:0]        digit_cnt_o,
  output logic              entry_err_o,
  output logic              busy_o
);
  state_e state_q, state_d;
  logic [CODE_W-1:0] acc_q, acc_d, code_q, code_d, digit_ext;
  logic [2:0] cnt_q, cnt_d;
  logic valid_q, valid_d, err_q, err_d, busy_q, expired;
  logic is_digit, is_clear, is_enter, full;
  assign is_digit = key_valid_i && key_code_i < 4'd10;
  assign is_clear = key_valid_i && key_code_i == KEY_CLEAR;
  assign is_enter = key_valid_i && key_code_i == KEY_ENTER;
  assign full = cnt_q == 3'(NUM_DIGITS);
  assign digit_ext = CODE_W'(key_code_i);
  entry_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (key_valid_i),
    .en_i     (state_q == ENTRY),
    .expired_o(expired)
  );
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    code_d = code_q;
    valid_d = valid_q;
    err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_digit) begin
          state_d = ENTRY;
          acc_d = digit_ext;
          cnt_d = 3'd1;
        end else if (is_enter) err_d = 1'b1;
      end
      ENTRY: begin
        if (is_digit) begin
          if (full) err_d = 1'b1;
          else begin
            acc_d = (acc_q << 3) + (acc_q << 1) + digit_ext;
            cnt_d = cnt_q + 3'd1;
          end
        end else if (is_clear) begin
          state_d = IDLE;
          acc_d = '0;
          cnt_d = '0;
        end else if (is_enter && full) begin
          state_d = HOLD;
          code_d = acc_q;
          valid_d = 1'b1;
        end else if (is_enter || (!key_valid_i && expired)) begin
          state_d = IDLE;
          err_d = 1'b1;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      HOLD: begin
        if (valid_q && code_ready_i) begin
          state_d = IDLE;
          code_d = '0;
          valid_d = 1'b0;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      code_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      code_q <= code_d;
      valid_q <= valid_d;
      err_q <= err_d;
      busy_q <= state_d != IDLE;
    end
  end
  assign code_o = code_q;
  assign code_valid_o = valid_q;
  assign digit_cnt_o = cnt_q;
  assign entry_err_o = err_q;
  assign busy_o = busy_q;
endmodule
